uni_stream_accum: RTL and testbench
===================================

// Module: uni_stream_accum
// PURPOSE
// - Downstream stage of the 16-input unipolar stochastic MAC: converts its 1-bit OR-add output stream back to binary.
// - After a start pulse, discards SKIP warm-up cycles of MAC latency, then counts the 1s over a window of 2**WIN_LOG2 cycles.
// - Presents the count on a valid/ready output port and holds it until the consumer accepts it.
// PARAMETERS
// - WIN_LOG2  8  log2 of the counting window in cycles (default window 256, one full 8-bit Sobol period)
// - SKIP      2  warm-up cycles discarded after start: the registered multiplier stage plus the registered OR-add stage
// PORTS
// - clk      in   1           clock, all state on rising edge
// - rst_n    in   1           asynchronous reset, active low
// - start    in   1           begin a conversion; sampled in IDLE, or in DONE on the handshake cycle
// - abort    in   1           synchronous abort; discards any conversion in progress
// - inBit    in   1           stochastic bit from the MAC output oC
// - busy     out  1           high in WARM and RUN
// - oValid   out  1           result valid; high in DONE only
// - iReady   in   1           consumer accepts the result when oValid && iReady
// - oCount   out  WIN_LOG2+1  exact count of 1s in the window, range 0..2**WIN_LOG2
// - oValue   out  WIN_LOG2    saturated count, min(oCount, 2**WIN_LOG2-1); unipolar value = oValue/2**WIN_LOG2
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, busy=0, oValid=0, oCount=0, oValue=0, all internal counters 0.
// - FSM states: IDLE, WARM, RUN, DONE (enum in package).
// - IDLE: start=1 -> WARM if SKIP>0, otherwise RUN. Clears the ones-counter and the cycle counter.
// - WARM: cycle counter runs 0..SKIP-1 and inBit is ignored. At SKIP-1 -> RUN and the cycle counter clears.
// - RUN: each cycle, onesCnt += inBit. The cycle counter runs 0..2**WIN_LOG2-1.
//   - In the last RUN cycle, the sample from that cycle is included.
//   - oCount/oValue are registered from the final total, and the state -> DONE.
// - DONE: oValid=1; oCount and oValue are stable and not modified until the handshake.
//   - oValid && iReady && !start -> IDLE; oValid drops on the next cycle.
//   - oValid && iReady && start -> WARM (or RUN): back-to-back conversion with no idle cycle.
//   - iReady=0: hold indefinitely.
// - Timing: start accepted at edge t -> first counted sample at cycle t+SKIP+1 -> oValid high from cycle t+SKIP+2**WIN_LOG2+1.
// - start in WARM/RUN: ignored, with no restart. start in DONE without iReady: ignored.
// - abort=1 in any state -> IDLE on the next edge; counters cleared; oValid=0.
//   - oCount/oValue keep their last accepted values.
//   - abort beats start and the handshake in the same cycle; that result is not counted as delivered.
// - Width rules:
//   - onesCnt is WIN_LOG2+1 bits and cannot overflow; an all-ones stream gives oCount = 2**WIN_LOG2 and oValue = 2**WIN_LOG2-1.
//   - The cycle counter is max(WIN_LOG2, clog2(SKIP)) bits and wraps to 0 on every state change.
// - inBit X while in IDLE/DONE has no effect. Mid-operation reset behaves exactly as power-on reset.
// STRUCTURE
// - Package sc_accum_pkg:
//   - accum_state_e {IDLE, WARM, RUN, DONE}
//   - function win_len(WIN_LOG2)
//   - default localparams for WIN_LOG2=8, SKIP=2
// - Sub-module sc_window_timer: a loadable down-counter with a terminal-count flag, used for both the WARM and RUN phases.
// - The top level holds the FSM, the ones-counter, the output registers and the saturation logic.
// TESTING
// - All-ones: start, inBit=1 throughout, iReady=1.
//   -> oValid first high 259 cycles after the start edge; oCount=256, oValue=255.
// - All-zeros and alternating 1010...: -> oCount=0 and oCount=128 respectively; no 1 driven during WARM is counted.
// - Back-pressure: iReady=0 for 50 cycles after oValid.
//   -> oValid, oCount and oValue stable throughout; the result is accepted on the cycle iReady rises.
// - Back-to-back: start=1 on the handshake cycle with a second stream of 64 ones.
//   -> busy with no IDLE gap; second result oCount=64.
// - Abort and restart:
//   - abort at RUN cycle 100 -> IDLE next cycle, oValid never asserted.
//   - A restart then yields a fresh count that excludes pre-abort ones.
// - Async reset mid-RUN: rst_n low for 3 cycles -> all outputs 0 immediately; start is ignored while rst_n=0.

Source files
------------

// File: rtl/sc_accum_pkg.sv
// Shared types and defaults for the unipolar stochastic stream accumulator.
package sc_accum_pkg;

    localparam int DEF_WIN_LOG2 = 8;
    localparam int DEF_SKIP     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } accum_state_e;

    function automatic int win_len(input int log2);
        return 1 << log2;
    endfunction

endpackage

// File: rtl/sc_window_timer.sv
// Loadable down-counter with a terminal-count flag; times both the warm-up and the counting window.
module sc_window_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/uni_stream_accum.sv
// Converts the 1-bit OR-add stream of the stochastic MAC back to a binary count over a fixed window.
module uni_stream_accum
    import sc_accum_pkg::*;
#(
    parameter int WIN_LOG2 = DEF_WIN_LOG2,
    parameter int SKIP     = DEF_SKIP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                inBit,
    output logic                busy,
    output logic                oValid,
    input  logic                iReady,
    output logic [WIN_LOG2:0]   oCount,
    output logic [WIN_LOG2-1:0] oValue
);

    localparam int SKIP_BITS = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int CW        = (WIN_LOG2 > SKIP_BITS) ? WIN_LOG2 : SKIP_BITS;

    // The timer holds "cycles remaining - 1", so terminal count marks the last cycle of a phase.
    localparam logic [CW-1:0]  RUN_LOAD    = CW'(win_len(WIN_LOG2) - 1);
    localparam logic [CW-1:0]  FIRST_LOAD  = (SKIP > 0) ? CW'(SKIP - 1) : RUN_LOAD;
    localparam accum_state_e   FIRST_STATE = (SKIP > 0) ? WARM : RUN;

    accum_state_e          state;
    logic [WIN_LOG2:0]     ones_cnt;
    logic [WIN_LOG2:0]     total;
    logic [WIN_LOG2-1:0]   sat;
    logic                  launch;
    logic                  t_load;
    logic                  t_en;
    logic [CW-1:0]         t_val;
    logic                  t_tc;

    assign launch = start && ((state == IDLE) || ((state == DONE) && iReady));
    assign total  = ones_cnt + {{WIN_LOG2{1'b0}}, inBit};
    assign sat    = total[WIN_LOG2] ? {WIN_LOG2{1'b1}} : total[WIN_LOG2-1:0];
    assign busy   = (state == WARM) || (state == RUN);
    assign oValid = (state == DONE);

    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        t_en   = 1'b0;
        if (abort) begin
            t_load = 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    t_load = 1'b1;
                    if (launch) t_val = FIRST_LOAD;
                end
                WARM: begin
                    if (t_tc) begin
                        t_load = 1'b1;
                        t_val  = RUN_LOAD;
                    end else begin
                        t_en = 1'b1;
                    end
                end
                RUN: begin
                    if (t_tc) t_load = 1'b1;
                    else      t_en   = 1'b1;
                end
                default: t_load = 1'b1;
            endcase
        end
    end

    sc_window_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .tc       (t_tc)
    );

    // Output registers only change when a window completes, so abort leaves the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ones_cnt <= '0;
            oCount   <= '0;
            oValue   <= '0;
        end else if (abort) begin
            state    <= IDLE;
            ones_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        ones_cnt <= '0;
                        state    <= FIRST_STATE;
                    end
                end
                WARM: begin
                    if (t_tc) state <= RUN;
                end
                RUN: begin
                    ones_cnt <= total;
                    if (t_tc) begin
                        oCount <= total;
                        oValue <= sat;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (iReady) begin
                        ones_cnt <= '0;
                        state    <= launch ? FIRST_STATE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uni_stream_accum.sv
// Directed bench for uni_stream_accum: table-driven windows plus back-pressure, back-to-back, abort and reset sequences.
module tb_uni_stream_accum;

    localparam int WIN_LOG2 = 8;
    localparam int SKIP     = 2;
    localparam int WIN      = 256;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       inBit;
    logic       busy;
    logic       oValid;
    logic       iReady;
    logic [8:0] oCount;
    logic [7:0] oValue;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        string name;
        int    kind;
        logic  warm;
        int    exp_count;
        int    exp_value;
    } vec_t;

    vec_t vecs[5];

    uni_stream_accum #(.WIN_LOG2(WIN_LOG2), .SKIP(SKIP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .inBit  (inBit),
        .busy   (busy),
        .oValid (oValid),
        .iReady (iReady),
        .oCount (oCount),
        .oValue (oValue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Stream patterns indexed by the RUN sample number 0..WIN-1.
    function automatic logic pattern_bit(input int kind, input int k);
        case (kind)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (k % 2 == 0);
            3:       return (k < 64);
            4:       return (k % 4 == 3);
            default: return 1'b0;
        endcase
    endfunction

    // Called at a negedge: pulses start, then drives warm-up and window bits until oValid shows.
    // lat is the number of negedges after the start edge at which oValid is first seen (-1 on timeout).
    task automatic apply_stimulus(input int kind, input logic warm, input bit b2b, output int lat);
        lat    = -1;
        start  = 1'b1;
        iReady = b2b;
        inBit  = warm;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            start  = 1'b0;
            iReady = 1'b0;
            if (b2b && i == 1) begin
                check_output("b2b_busy", busy, 1);
                check_output("b2b_valid_low", oValid, 0);
            end
            if (oValid) begin
                lat = i;
                break;
            end
            if (i <= SKIP)                inBit = warm;
            else if (i - SKIP - 1 < WIN)  inBit = pattern_bit(kind, i - SKIP - 1);
            else                          inBit = 1'b0;
        end
        check_output("valid_timeout", (lat > 0) ? 1 : 0, 1);
    endtask

    task automatic handshake();
        iReady = 1'b1;
        @(negedge clk);
        iReady = 1'b0;
        check_output("valid_drop", oValid, 0);
    endtask

    initial begin
        int lat;
        int bad;
        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0] = '{"all_ones",  0, 1'b1, 256, 255};
        vecs[1] = '{"all_zeros", 1, 1'b1,   0,   0};
        vecs[2] = '{"alternate", 2, 1'b1, 128, 128};
        vecs[3] = '{"first64",   3, 1'b0,  64,  64};
        vecs[4] = '{"every4th",  4, 1'b1,  64,  64};

        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        inBit  = 1'b0;
        iReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("reset_busy",   busy,   0);
        check_output("reset_valid",  oValid, 0);
        check_output("reset_count",  oCount, 0);
        check_output("reset_value",  oValue, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            apply_stimulus(vecs[v].kind, vecs[v].warm, 1'b0, lat);
            check_output({vecs[v].name, "_latency"}, lat, SKIP + WIN + 1);
            check_output({vecs[v].name, "_count"}, oCount, vecs[v].exp_count);
            check_output({vecs[v].name, "_value"}, oValue, vecs[v].exp_value);
            check_output({vecs[v].name, "_busy"}, busy, 0);
            handshake();
            @(negedge clk);
        end

        // Back-pressure: result must sit unchanged until iReady rises.
        apply_stimulus(2, 1'b1, 1'b0, lat);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(oValid && oCount == 9'd128 && oValue == 8'd128)) bad++;
        end
        check_output("bp_unstable_cycles", bad, 0);
        handshake();
        check_output("bp_busy_after", busy, 0);

        // Back-to-back: second start on the handshake cycle.
        @(negedge clk);
        apply_stimulus(0, 1'b1, 1'b0, lat);
        check_output("b2b_first_count", oCount, 256);
        apply_stimulus(3, 1'b1, 1'b1, lat);
        check_output("b2b_latency", lat, SKIP + WIN + 1);
        check_output("b2b_second_count", oCount, 64);
        check_output("b2b_second_value", oValue, 64);
        handshake();

        // Abort around RUN cycle 100, then a clean restart.
        @(negedge clk);
        start = 1'b1;
        inBit = 1'b1;
        for (int i = 1; i <= 102; i++) begin
            @(negedge clk);
            start = 1'b0;
            inBit = 1'b1;
        end
        check_output("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_busy", busy, 0);
        check_output("abort_valid", oValid, 0);
        check_output("abort_keeps_count", oCount, 64);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (oValid || busy) bad++;
        end
        check_output("abort_stays_idle", bad, 0);
        apply_stimulus(2, 1'b1, 1'b0, lat);
        check_output("restart_latency", lat, SKIP + WIN + 1);
        check_output("restart_count", oCount, 128);
        handshake();

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1;
        inBit = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check_output("arst_busy",  busy,   0);
        check_output("arst_valid", oValid, 0);
        check_output("arst_count", oCount, 0);
        check_output("arst_value", oValue, 0);
        repeat (3) @(negedge clk);
        check_output("arst_start_ignored", busy, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("arst_post_busy",  busy,   0);
        check_output("arst_post_valid", oValid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
